// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned NUM_MEM_REQUESTERS = 2;
  localparam int unsigned REQ_ID_W           = 1;
  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // One read-return tracker entry: is a read in this slot, and who issued it.
  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } rd_tag_t;

  function automatic logic [NUM_MEM_REQUESTERS-1:0] id_to_onehot(input logic [REQ_ID_W-1:0] id);
    return NUM_MEM_REQUESTERS'(1) << id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_return_tracker.sv
// {valid, id} delay line that steers rvalid back to the requester that issued each read.
module rd_return_tracker
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid_in,
  input  logic [REQ_ID_W-1:0]           push_id_in,
  output logic [NUM_MEM_REQUESTERS-1:0] rvalid_out
);

  rd_tag_t [DEPTH-1:0] stage_q;
  rd_tag_t [DEPTH-1:0] stage_d;

  // Shift a new tag in at stage 0; older tags move one slot toward the output.
  always_comb begin
    stage_d          = '0;
    stage_d[0].valid = push_valid_in;
    stage_d[0].id    = push_id_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tracker storage; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Decode the oldest slot straight from flops into a per-requester valid.
  always_comb begin
    rvalid_out = '0;
    if (stage_q[DEPTH-1].valid) begin
      rvalid_out = id_to_onehot(stage_q[DEPTH-1].id);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bus lock sharing the memory_system data port between
// the CPU LSU (requester 0) and the debug/program loader (requester 1).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_LOCK_CYCLES = 16
) (
  input  logic                                      clk_in,
  input  logic                                      rst_low_in,
  input  logic [NUM_MEM_REQUESTERS-1:0]             req_in,
  input  logic [NUM_MEM_REQUESTERS-1:0]             lock_in,
  input  logic [NUM_MEM_REQUESTERS-1:0]             we_in,
  input  logic [NUM_MEM_REQUESTERS-1:0][ADDR_W-1:0] addr_in,
  input  logic [NUM_MEM_REQUESTERS-1:0][DATA_W-1:0] wr_data_in,
  output logic [NUM_MEM_REQUESTERS-1:0]             gnt_out,
  output logic [NUM_MEM_REQUESTERS-1:0]             rvalid_out,
  output logic [DATA_W-1:0]                         rd_data_out,
  output logic [ADDR_W-1:0]                         mem_addr_out,
  output logic [DATA_W-1:0]                         mem_wr_data_out,
  output logic                                      mem_we_out,
  input  logic [DATA_W-1:0]                         mem_rd_data_in
);

  localparam int unsigned LOCK_CNT_W = $clog2(MAX_LOCK_CYCLES + 1);

  arb_state_t            state_q, state_d;
  logic [REQ_ID_W-1:0]   last_gnt_q, last_gnt_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic                  gnt_any;
  logic [REQ_ID_W-1:0]   gnt_id;
  logic [REQ_ID_W-1:0]   lock_id;

  assign gnt_any = |gnt_out;
  assign gnt_id  = gnt_out[1];
  assign lock_id = (state_q == LOCK1);

  // Grant: lock owner only while locked, else non-last_gnt wins a conflict; nothing during reset.
  always_comb begin
    gnt_out = '0;
    if (rst_low_in) begin
      case (state_q)
        LOCK0:   gnt_out[0] = req_in[0];
        LOCK1:   gnt_out[1] = req_in[1];
        default: begin
          if (req_in == 2'b11) begin
            gnt_out = id_to_onehot(~last_gnt_q);
          end else begin
            gnt_out = req_in;
          end
        end
      endcase
    end
  end

  // Memory port mux follows the grant; idle port drives zeros.
  always_comb begin
    mem_addr_out    = '0;
    mem_wr_data_out = '0;
    mem_we_out      = 1'b0;
    if (gnt_any) begin
      mem_addr_out    = addr_in[gnt_id];
      mem_wr_data_out = wr_data_in[gnt_id];
      mem_we_out      = we_in[gnt_id];
    end
  end

  // Next state: lock entry/exit, lock timeout and round-robin history.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = '0;
    if (gnt_any) begin
      last_gnt_d = gnt_id;
    end
    case (state_q)
      LOCK0, LOCK1: begin
        if (lock_cnt_q == LOCK_CNT_W'(MAX_LOCK_CYCLES - 1)) begin
          // Forced release; owner counts as last so the other side wins next.
          state_d    = ARB;
          last_gnt_d = lock_id;
        end else if (!lock_in[lock_id]) begin
          // Either the final locked transfer or an idle release.
          state_d = ARB;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end
      end
      default: begin
        if (gnt_any && lock_in[gnt_id]) begin
          state_d = gnt_id ? LOCK1 : LOCK0;
        end
      end
    endcase
  end

  // Arbiter state registers; requester 0 wins the first conflict after reset.
  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      state_q    <= ARB;
      last_gnt_q <= REQ_ID_W'(1);
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  rd_return_tracker #(
    .DEPTH (READ_LATENCY)
  ) u_rd_return_tracker (
    .clk           (clk_in),
    .rst_n         (rst_low_in),
    .push_valid_in (gnt_any & ~mem_we_out),
    .push_id_in    (gnt_id),
    .rvalid_out    (rvalid_out)
  );

  // Read data needs no extra stage: the tracker is aligned to the memory latency.
  assign rd_data_out = mem_rd_data_in;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single data port of `memory_system` between the CPU load/store unit (requester 0) and a debug/program-loader master (requester 1). Sits between `risc_v_cpu` and `memory_system` in `risc_v_wrapper`. It provides:
- round-robin grant;
- optional bus lock for atomic read-modify-write;
- return routing of read data, tracking each in-flight read so `rvalid` reaches the requester that issued it.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from the grant edge to valid `mem_rd_data_in`. Legal range 1..4.
- `MAX_LOCK_CYCLES`, default 16: maximum consecutive cycles one requester may hold a lock before it is forcibly released.

Ports:
- `clk_in` in 1: system clock (`sys_clk`).
- `rst_low_in` in 1: reset, asynchronous, active-low.
- `req_in` in [1:0]: per-requester access request.
- `lock_in` in [1:0]: per-requester lock request, qualified by `req_in`.
- `we_in` in [1:0]: per-requester write enable.
- `addr_in` in [1:0][31:0]: per-requester byte address.
- `wr_data_in` in [1:0][31:0]: per-requester write data.
- `gnt_out` out [1:0]: one-hot grant (combinational).
- `rvalid_out` out [1:0]: per-requester read-data valid (registered).
- `rd_data_out` out 32: read data, broadcast to both requesters.
- `mem_addr_out` out 32: address to `memory_system`.
- `mem_wr_data_out` out 32: write data to `memory_system`.
- `mem_we_out` out 1: write enable to `memory_system`.
- `mem_rd_data_in` in 32: read data from `memory_system`.

## Operation
- One transfer per cycle. A requester holding `req_in` high in a cycle with its `gnt_out` high has its transfer accepted at the next rising edge.
- `gnt_out` is combinational from `req_in` and the arbiter state. At most one bit is set. It is 0 when no request is eligible.

Round-robin arbitration:
- `last_gnt` is a register updated on every accepted transfer.
- The requester not equal to `last_gnt` has priority.
- A lone requester is granted immediately.

State machine, with states `ARB`, `LOCK0`, `LOCK1`:
- `ARB` → `LOCKn` when requester n is granted with `lock_in[n]`=1.
- In `LOCKn`:
  - only requester n is eligible;
  - requester n is granted whenever `req_in[n]`=1;
  - the other requester waits.
- `LOCKn` → `ARB` when either:
  - requester n is granted with `lock_in[n]`=0 (that transfer is the last of the locked sequence); or
  - `lock_in[n]` is sampled 0 with `req_in[n]`=0 (lock released).
- Lock timeout: `lock_cnt` counts cycles spent in `LOCKn`. When it reaches `MAX_LOCK_CYCLES`, the arbiter returns to `ARB` and `last_gnt` is set to n, so the other requester wins the next conflict.

Memory port:
- `mem_addr_out` and `mem_wr_data_out` mux the granted requester's inputs. They are 0 when nothing is granted.
- `mem_we_out` = grant & `we_in` of the granted requester.

Read tracking:
- A shift register of depth `READ_LATENCY`. Each entry holds {valid, id}.
- A granted read (`we`=0) enters with valid=1 and id=granted requester. Writes and idle cycles enter valid=0.
- Output stage: `rvalid_out[id]` = valid. `rd_data_out` is `mem_rd_data_in` registered... with no extra register: `rd_data_out` is wired directly to `mem_rd_data_in`, and the tracker is aligned so that `rvalid` coincides with valid data.

## Timing
- Reset values:
  - `gnt_out`=0 (no requests can be eligible during reset);
  - `rvalid_out`=0;
  - state=`ARB`, `last_gnt`=1 (requester 0 wins the first conflict);
  - `lock_cnt`=0;
  - tracker cleared.
  - `mem_we_out`=0 while reset is asserted.
- Read latency: a read granted in cycle T has `rvalid_out` high in cycle T+`READ_LATENCY` for exactly one cycle.
- Back-to-back reads give one `rvalid` per cycle.
- Write: complete at the grant edge. No response.
- Simultaneous requests in `ARB`: the non-`last_gnt` requester wins; the loser holds `req_in` and is granted next cycle (assuming no lock taken).
- Requester changing `addr_in`/`we_in` while ungranted: no effect.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is produced. A lock is dropped.
- Requester deasserting `req_in` without a grant is legal.

## Structure
- Add to `memory_system_pkg`:
  - `typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t`;
  - `NUM_MEM_REQUESTERS = 2`.
- One sub-module: `rd_return_tracker`, the parameterised {valid, id} delay line. Its depth is `READ_LATENCY`.
- Instantiated in `risc_v_wrapper` between `cpu_inst` and `mem_sys_inst`.

## Test plan
- Reset then idle: `gnt_out`=00, `rvalid_out`=00, `mem_we_out`=0 for 10 cycles.
- Both requesters post reads continuously, addrs 0x100/0x200:
  - grants alternate 01,10,01,…, with requester 0 first;
  - each `rvalid` arrives `READ_LATENCY` cycles after its grant, carrying data from the correct address.
- Requester 1 locks: read 0x40 with lock=1, then write 0x40 with lock=0, while requester 0 requests throughout.
  - Requester 0 sees no grant until after the write.
  - `mem_we_out` pulses once, with addr 0x40.
- Requester 0 holds lock=1 and `req_in`=1 indefinitely with `MAX_LOCK_CYCLES`=16:
  - forced release after 16 cycles;
  - requester 1 granted on the next cycle.
- `READ_LATENCY`=3, with 3 reads in flight: assert `rst_low_in`=0 asynchronously mid-cycle.
  - Outputs clear immediately.
  - No `rvalid` after reset release.
- Single requester 1 writes 0xDEADBEEF to 0x80, then reads 0x80: granted same cycle as request each time, `rd_data_out`=0xDEADBEEF with `rvalid_out`=10.
